// File: rtl/fsm_maint_monitor.sv
// Maintenance-event monitor and watchdog: counts rising edges on x, raises a
// sticky error when no event arrives within TIMEOUT cycles, cleared by ack.
module fsm_maint_monitor #(
  parameter int unsigned      CNT_W    = 8,
  parameter int unsigned      TIMEOUT  = 100,
  parameter logic [CNT_W-1:0] ERR_CODE = '1,
  parameter bit               SATURATE = 1'b1,
  parameter int unsigned      ERR_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         x,
  input  logic                         ack,
  input  logic                         clr_cnt,
  output logic [1:0]                   current_state,
  output logic [CNT_W-1:0]             reg_state,
  output logic [CNT_W-1:0]             count,
  output logic [$clog2(TIMEOUT+1)-1:0] timer,
  output logic                         error,
  output logic                         ovf,
  output logic [ERR_W-1:0]             err_count
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COUNT = 2'b01,
    S_ERROR = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic               x_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               ovf_q, ovf_d;
  logic               rise;
  logic               inc;

  assign rise = x & ~x_q;

  // NOTE: every signal driven here gets a default before the case so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    ovf_d     = 1'b0;
    inc       = 1'b0;

    case (state_q)
      S_IDLE: begin
        timer_d = timer_q + 1'b1;
        if (rise) begin
          state_d = S_COUNT;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ERROR;
          timer_d = '0;
        end
      end
      S_COUNT: begin
        state_d = S_IDLE;
        timer_d = '0;
        inc     = 1'b1;
      end
      S_ERROR: begin
        timer_d = '0;
        if (ack) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    if (state_d == S_ERROR && state_q != S_ERROR && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end

    // A clear wins over a coinciding increment and swallows its wrap pulse.
    if (clr_cnt) begin
      count_d = '0;
    end else if (inc) begin
      if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end else if (!SATURATE) begin
        count_d = '0;
        ovf_d   = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      x_q       <= 1'b1;  // x held high across reset release is not an event
      count_q   <= '0;
      timer_q   <= '0;
      err_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x;
      count_q   <= count_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign current_state = state_q;
  assign error         = (state_q == S_ERROR);
  assign reg_state     = error ? ERR_CODE : count_q;
  assign count         = count_q;
  assign timer         = timer_q;
  assign err_count     = err_cnt_q;
  assign ovf           = SATURATE ? 1'b0 : ovf_q;

endmodule
